// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-ported memory shared by fetch and data.
// Fixed-latency issue/wait/response sequencing with fetch anti-starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_LD = 4'(MEM_LAT - 1);
  localparam logic [3:0] S_MAX  = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nx;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       gnt_d;
  logic       we_r;
  logic       any_req;
  logic       pick_if;
  logic       unused_addr_lsb;

  assign any_req = if_req | dm_req;
  assign pick_if = if_req & (~dm_req | (starve_cnt == S_MAX));

  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) & we_r;
  assign busy      = (state != IDLE);
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  assign unused_addr_lsb = ^{if_addr[1:0], dm_addr[1:0]};

  // Next-state: one access at a time, no back-to-back issue.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (lat_cnt <= 4'd1) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Latency counter: loaded on issue, counts down the wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= LAT_LD;
    end else if (state == WAIT) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Latch the winner's request so the memory sees only that requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_d     <= 1'b0;
      we_r      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_d <= ~pick_if;
      we_r  <= ~pick_if & dm_we;
      if (pick_if) begin
        mem_addr <= if_addr[ADDR_W-1:2];
      end else begin
        mem_addr  <= dm_addr[ADDR_W-1:2];
        mem_wdata <= dm_wdata;
      end
    end
  end

  // Fetch anti-starvation: count data wins while fetch is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req || pick_if) begin
        starve_cnt <= '0;
      end else if (starve_cnt != S_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Response: capture read data and pulse the winner's ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (state == RESP) begin
        if (gnt_d) begin
          dm_ack <= 1'b1;
          if (!we_r) dm_rdata <= mem_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and a
// transaction-level random model for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we;
  logic        stall_if, stall_mem, busy;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;

  logic        l1_if_req, l1_dm_req, l1_dm_we;
  logic [31:0] l1_if_addr, l1_dm_addr, l1_dm_wdata;
  logic        l1_if_ack, l1_dm_ack, l1_mem_en, l1_mem_we;
  logic        l1_stall_if, l1_stall_mem, l1_busy;
  logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_wdata, l1_mem_rdata;
  logic [29:0] l1_mem_addr;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .busy(busy)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr),
    .if_ack(l1_if_ack), .if_rdata(l1_if_rdata),
    .dm_req(l1_dm_req), .dm_we(l1_dm_we),
    .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_ack(l1_dm_ack), .dm_rdata(l1_dm_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata),
    .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
    .busy(l1_busy)
  );

  // Memory models: read data valid exactly LAT cycles after mem_en,
  // random garbage at every other time.
  logic [31:0] env_mem [64];
  logic [31:0] l1_mem [64];
  logic [31:0] rpipe [3];
  logic [31:0] rpipe1 [2];

  always @(negedge clk) begin
    rpipe[2] <= rpipe[1];
    rpipe[1] <= rpipe[0];
    rpipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr[5:0]] : $urandom;
    if (mem_en && mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
  end
  assign mem_rdata = rpipe[LAT];

  always @(negedge clk) begin
    rpipe1[1] <= rpipe1[0];
    rpipe1[0] <= (l1_mem_en && !l1_mem_we) ? l1_mem[l1_mem_addr[5:0]] : $urandom;
    if (l1_mem_en && l1_mem_we) l1_mem[l1_mem_addr[5:0]] <= l1_mem_wdata;
  end
  assign l1_mem_rdata = rpipe1[1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [29:0] waddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vt [7];
  logic [31:0] exp_dm = 32'h0;

  task automatic run_vec(input vec_t v);
    int          n;
    int          en_n;
    bit          got;
    logic [29:0] a_seen;
    logic        we_seen;
    logic [31:0] wd_seen;
    @(posedge clk); #1;
    if (v.is_d) begin
      dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    n = 0; en_n = -1; got = 0;
    a_seen = '0; we_seen = 0; wd_seen = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      chk("stall", v.is_d ? stall_mem : stall_if, 1'b1);
      chk("busy", busy, (n >= 1) ? 1'b1 : 1'b0);
      if (mem_en) begin
        en_n = n; a_seen = mem_addr; we_seen = mem_we; wd_seen = mem_wdata;
      end
      @(posedge clk); #1;
      n++;
      if (v.is_d ? dm_ack : if_ack) got = 1;
    end
    chk("ack_lat", n, LAT + 2);
    chk("stall_at_ack", v.is_d ? stall_mem : stall_if, 1'b0);
    chk("other_ack", v.is_d ? if_ack : dm_ack, 1'b0);
    chk("issue_cyc", en_n, 1);
    chk("mem_addr", a_seen, v.waddr);
    chk("mem_we", we_seen, v.we);
    if (v.we) chk("mem_wdata", wd_seen, v.wdata);
    if (v.is_d) begin
      if (!v.we) exp_dm = v.rdata;
      chk("dm_rdata", dm_rdata, exp_dm);
    end else begin
      chk("if_rdata", if_rdata, v.rdata);
    end
    if_req = 0; dm_req = 0;
    @(posedge clk); #1;
    chk("ack_pulse", v.is_d ? dm_ack : if_ack, 1'b0);
    chk("idle_after", busy, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    return {24'h0, 8'($urandom_range(255, 0))};
  endfunction

  // Random-phase model state
  logic [31:0] shadow [64];
  int          cyc, free_at, issue_at, ack_at, starve;
  bit          o_d, o_we, e_en, e_ai, e_ad;
  logic [29:0] o_wa;
  logic [31:0] o_wd, o_rd, exp_if_rd, exp_dm_rd;

  int          n, d_at, i_at, k, bcnt;
  bit          seen;
  logic [9:0]  seq, seq_exp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] <= 32'h2002_0003 + i;
      l1_mem[i]  <= 32'h2002_0003 + i;
    end
    rst_n = 0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    l1_if_req = 0; l1_if_addr = 0; l1_dm_req = 0; l1_dm_we = 0;
    l1_dm_addr = 0; l1_dm_wdata = 0;

    vt[0] = '{0, 0, 32'h0000_0008, 32'h0,         30'h2,  32'h2002_0005};
    vt[1] = '{1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 30'h10, 32'h0};
    vt[2] = '{1, 0, 32'h0000_0040, 32'h0,         30'h10, 32'hDEAD_BEEF};
    vt[3] = '{0, 0, 32'h0000_0013, 32'h0,         30'h4,  32'h2002_0007};
    vt[4] = '{1, 1, 32'h0000_0007, 32'h1234_5678, 30'h1,  32'h0};
    vt[5] = '{1, 0, 32'h0000_0006, 32'h0,         30'h1,  32'h1234_5678};
    vt[6] = '{1, 0, 32'h0000_00FC, 32'h0,         30'h3F, 32'h2002_0042};

    #12;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {if_ack, dm_ack}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Reset while waiting on memory: everything clears, no late ack.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h10;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", {mem_en, mem_we}, 0);
    chk("mid_rst_acks", {if_ack, dm_ack}, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    chk("mid_rst_dm_rdata", dm_rdata, 0);
    chk("mid_rst_maddr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    if_req = 0;
    @(negedge clk); rst_n = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_ack || busy) seen = 1;
    end
    chk("no_ack_after_rst", seen, 0);
    exp_dm = 32'h0;

    // Simultaneous requests: data first, fetch right after.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h8;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    n = 0; d_at = -1; i_at = -1;
    while ((d_at < 0 || i_at < 0) && n < 30) begin
      @(posedge clk); #1; n++;
      if (dm_ack) begin d_at = n; dm_req = 0; end
      if (if_ack) begin i_at = n; if_req = 0; end
    end
    chk("simul_dm_ack", d_at, 4);
    chk("simul_if_ack", i_at, 8);
    chk("simul_if_rdata", if_rdata, 32'h2002_0005);
    chk("simul_dm_rdata", dm_rdata, 32'hDEAD_BEEF);

    // Starvation: both held; four data grants then one fetch, twice.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h8;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    n = 0; k = 0; seq = '0;
    while (k < 10 && n < 200) begin
      @(posedge clk); #1; n++;
      if (if_ack || dm_ack) begin
        seq[k] = if_ack;
        k++;
      end
    end
    if_req = 0; dm_req = 0;
    seq_exp = 10'b10000_10000;
    chk("starve_count", k, 10);
    chk("starve_seq", seq, seq_exp);
    repeat (2) @(posedge clk);

    // One-cycle latency build: no wait state.
    @(posedge clk); #1;
    l1_dm_req = 1; l1_dm_we = 0; l1_dm_addr = 32'h8;
    n = 0; bcnt = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (l1_busy) bcnt++;
      @(posedge clk); #1; n++;
      if (l1_dm_ack) seen = 1;
    end
    l1_dm_req = 0;
    chk("l1_ack_lat", n, 3);
    chk("l1_busy_cycles", bcnt, 2);
    chk("l1_busy_at_ack", l1_busy, 0);
    chk("l1_dm_rdata", l1_dm_rdata, 32'h2002_0005);

    // Random traffic against a transaction-level model.
    rst_n = 0;
    #20;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 64; i++) shadow[i] = env_mem[i];
    exp_if_rd = 0; exp_dm_rd = 0;
    cyc = 0; free_at = 0; issue_at = -100; ack_at = -100; starve = 0;
    o_d = 0; o_we = 0; o_wa = '0; o_wd = '0; o_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (cyc >= free_at) begin
        if (if_req || dm_req) begin
          o_d = !(if_req && (!dm_req || starve == SMAX));
          if (!o_d) begin
            starve = 0;
            o_we = 0;
            o_wa = if_addr[31:2];
          end else begin
            starve = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
            o_we = dm_we;
            o_wa = dm_addr[31:2];
            o_wd = dm_wdata;
          end
          if (o_we) shadow[o_wa[5:0]] = o_wd;
          else      o_rd = shadow[o_wa[5:0]];
          issue_at = cyc + 1;
          ack_at   = cyc + LAT + 2;
          free_at  = ack_at;
        end else begin
          starve = 0;
        end
      end
      cyc++;
      #1;
      e_en = (cyc == issue_at);
      e_ai = (cyc == ack_at) && !o_d;
      e_ad = (cyc == ack_at) && o_d;
      if (e_ai) exp_if_rd = o_rd;
      if (e_ad && !o_we) exp_dm_rd = o_rd;
      chk("r_mem_en", mem_en, e_en);
      chk("r_mem_we", mem_we, e_en && o_we);
      chk("r_busy", busy, (cyc >= issue_at && cyc < ack_at));
      chk("r_if_ack", if_ack, e_ai);
      chk("r_dm_ack", dm_ack, e_ad);
      chk("r_if_rdata", if_rdata, exp_if_rd);
      chk("r_dm_rdata", dm_rdata, exp_dm_rd);
      if (e_en) chk("r_mem_addr", mem_addr, o_wa);
      if (e_en && o_we) chk("r_mem_wdata", mem_wdata, o_wd);
      if (if_req && if_ack) begin
        if ($urandom_range(1, 0) == 0) if_req = 0;
        else if_addr = rand_addr();
      end else if (!if_req && $urandom_range(2, 0) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (dm_req && dm_ack) begin
        if ($urandom_range(1, 0) == 0) dm_req = 0;
        else begin
          dm_addr = rand_addr(); dm_we = 1'($urandom_range(1, 0));
          dm_wdata = $urandom;
        end
      end else if (!dm_req && $urandom_range(2, 0) == 0) begin
        dm_req = 1; dm_addr = rand_addr();
        dm_we = 1'($urandom_range(1, 0)); dm_wdata = $urandom;
      end
      @(negedge clk);
      chk("r_stall_if", stall_if, if_req && !e_ai);
      chk("r_stall_mem", stall_mem, dm_req && !e_ad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
